// File: rtl/synth_pkg.sv
// Shared synthesis types: period word shared with the key-to-period mapper,
// and the PCM sample type handed to the audio output stage.
package synth_pkg;

   localparam int LARGURA_CP = 18;
   localparam logic [LARGURA_CP-1:0] CP_INATIVO = '1;

   typedef logic [LARGURA_CP-1:0] t_cp;
   typedef logic signed [15:0]    t_amostra;

endpackage

// File: rtl/oscilador_voz.sv
// One square-wave voice: phase counter over cp clk cycles, active detect,
// and a signed +/-AMPLITUDE (or zero) contribution to the mix.
module oscilador_voz #(
   parameter int LARGURA_CP   = 18,
   parameter int LARGURA_SOMA = 21,
   parameter int AMPLITUDE    = 3000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    habilita,
   input  logic [LARGURA_CP-1:0]   cp,
   output logic                    ativa,
   output logic [LARGURA_SOMA-1:0] contrib
);

   localparam logic [LARGURA_SOMA-1:0] AMP_P = LARGURA_SOMA'(AMPLITUDE);
   localparam logic [LARGURA_SOMA-1:0] AMP_N = LARGURA_SOMA'(-AMPLITUDE);

   logic [LARGURA_CP-1:0] cont;
   logic                  periodo_ok;
   logic                  ativa_r;
   logic                  alta;

   assign periodo_ok = (cp != {LARGURA_CP{1'b1}}) && (cp >= LARGURA_CP'(2));

   // ativa_r delays the start by one edge so every note begins at cont=0 (high phase)
   assign ativa = habilita & periodo_ok & ativa_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cont    <= '0;
         ativa_r <= 1'b0;
      end else begin
         ativa_r <= habilita & periodo_ok;
         if (!ativa)
            cont <= '0;
         else if (cont >= cp - LARGURA_CP'(1))
            cont <= '0;
         else
            cont <= cont + LARGURA_CP'(1);
      end
   end

   assign alta    = cont < (cp >> 1);
   assign contrib = !ativa ? '0 : (alta ? AMP_P : AMP_N);

endmodule

// File: rtl/oscilador_polifonico.sv
// Polyphonic square-wave synthesizer: per-voice oscillators, signed mixer and
// sample-rate output register. Define OSC_SATURA_EN to clamp instead of wrap.
module oscilador_polifonico #(
   parameter int NR_TECLAS       = 10,
   parameter int LARGURA_CP      = synth_pkg::LARGURA_CP,
   parameter int DIV_AMOSTRA     = 1042,
   parameter int AMPLITUDE       = 3000,
   parameter int LARGURA_AMOSTRA = $bits(synth_pkg::t_amostra)
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NR_TECLAS-1:0][LARGURA_CP-1:0]     cp,
   input  logic                                     habilita,
   output logic signed [LARGURA_AMOSTRA-1:0]        amostra,
   output logic                                     amostra_valida,
   output logic [$clog2(NR_TECLAS+1)-1:0]           vozes_ativas
);

   localparam int LARGURA_SOMA = LARGURA_AMOSTRA + $clog2(NR_TECLAS) + 1;
   localparam int W_VOZ        = $clog2(NR_TECLAS+1);
   localparam int W_DIV        = $clog2(DIV_AMOSTRA);

   logic [NR_TECLAS-1:0][LARGURA_SOMA-1:0] contrib;
   logic [NR_TECLAS-1:0]                   ativa;
   logic signed [LARGURA_SOMA-1:0]         soma_c;
   logic signed [LARGURA_SOMA-1:0]         soma_r;
   logic [W_VOZ-1:0]                       nvoz;
   logic [W_DIV-1:0]                       div;
   logic                                   fim_div;

   for (genvar g = 0; g < NR_TECLAS; g++) begin : g_voz
      oscilador_voz #(
         .LARGURA_CP   (LARGURA_CP),
         .LARGURA_SOMA (LARGURA_SOMA),
         .AMPLITUDE    (AMPLITUDE)
      ) u_voz (
         .clk      (clk),
         .rst      (rst),
         .habilita (habilita),
         .cp       (cp[g]),
         .ativa    (ativa[g]),
         .contrib  (contrib[g])
      );
   end

   always_comb begin
      soma_c = '0;
      nvoz   = '0;
      for (int i = 0; i < NR_TECLAS; i++) begin
         soma_c = soma_c + $signed(contrib[i]);
         nvoz   = nvoz + W_VOZ'(ativa[i]);
      end
   end

   function automatic logic signed [LARGURA_AMOSTRA-1:0] reduzir(
      input logic signed [LARGURA_SOMA-1:0] s
   );
`ifdef OSC_SATURA_EN
      localparam logic signed [LARGURA_SOMA-1:0] S_MAX = LARGURA_SOMA'(2**(LARGURA_AMOSTRA-1) - 1);
      localparam logic signed [LARGURA_SOMA-1:0] S_MIN = LARGURA_SOMA'(-(2**(LARGURA_AMOSTRA-1)));
      if (s > S_MAX)
         return S_MAX[LARGURA_AMOSTRA-1:0];
      else if (s < S_MIN)
         return S_MIN[LARGURA_AMOSTRA-1:0];
      else
         return s[LARGURA_AMOSTRA-1:0];
`else
      return s[LARGURA_AMOSTRA-1:0];
`endif
   endfunction

   assign fim_div = habilita && (div == W_DIV'(DIV_AMOSTRA - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         soma_r         <= '0;
         vozes_ativas   <= '0;
         div            <= '0;
         amostra        <= '0;
         amostra_valida <= 1'b0;
      end else begin
         soma_r         <= soma_c;
         vozes_ativas   <= nvoz;
         amostra_valida <= fim_div;
         if (!habilita || fim_div)
            div <= '0;
         else
            div <= div + W_DIV'(1);
         // disabled output is silence, not the last sample
         if (!habilita)
            amostra <= '0;
         else if (fim_div)
            amostra <= reduzir(soma_r);
      end
   end

endmodule

// File: tb/tb_oscilador_polifonico.sv
// Self-checking bench for oscilador_polifonico: table-driven single-voice
// waveforms, hand sequences for corner cases, randomized voice toggling vs. a model.
module tb_oscilador_polifonico;

   localparam int NV    = 10;
   localparam int DIV   = 4;
   localparam int AMP_A = 3000;
   localparam int AMP_B = 4000;
   localparam logic [17:0] INAT = 18'h3FFFF;

   typedef struct {
      int voz;
      int per;
      int hi;
      int lo;
      int nvoz;
   } vec_t;

   logic clk, rst, habilita;
   logic [NV-1:0][17:0] cp_a, cp_b;
   logic signed [15:0] am_a, am_b;
   logic val_a, val_b;
   logic [3:0] vz_a, vz_b;

   int nchk = 0;
   int nerr = 0;
   int e    = 0;

   vec_t tab[7];
   int on[NV], ini[NV], per[NV];
   int sums[0:399], cnts[0:399];

   oscilador_polifonico #(.NR_TECLAS(NV), .DIV_AMOSTRA(DIV), .AMPLITUDE(AMP_A)) u_a (
      .clk(clk), .rst(rst), .cp(cp_a), .habilita(habilita),
      .amostra(am_a), .amostra_valida(val_a), .vozes_ativas(vz_a));

   oscilador_polifonico #(.NR_TECLAS(NV), .DIV_AMOSTRA(DIV), .AMPLITUDE(AMP_B)) u_b (
      .clk(clk), .rst(rst), .cp(cp_b), .habilita(habilita),
      .amostra(am_b), .amostra_valida(val_b), .vozes_ativas(vz_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      e++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      habilita = 1'b1;
      for (int i = 0; i < NV; i++) begin
         cp_a[i] = INAT;
         cp_b[i] = INAT;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      e = 0;
   endtask

   function automatic int red16(input int s);
`ifdef OSC_SATURA_EN
      if (s > 32767) return 32767;
      if (s < -32768) return -32768;
      return s;
`else
      logic signed [15:0] t;
      t = s[15:0];
      return int'(t);
`endif
   endfunction

   initial begin
      int c, k, x, found, found2, exp_am, v, r, s, cn, len;

      tab[0] = '{0, 8, 4, 4, 1};
      tab[1] = '{3, 7, 3, 4, 1};
      tab[2] = '{1, 2, 1, 1, 1};
      tab[3] = '{9, 11, 5, 6, 1};
      tab[4] = '{2, 3, 1, 2, 1};
      tab[5] = '{5, 1, 0, 0, 0};
      tab[6] = '{6, 'h3FFFF, 0, 0, 0};

      // reset state
      rst = 1'b1;
      habilita = 1'b0;
      for (int i = 0; i < NV; i++) begin
         cp_a[i] = INAT;
         cp_b[i] = INAT;
      end
      #12;
      chk("reset amostra", am_a, 0);
      chk("reset valida", val_a, 0);
      chk("reset vozes", vz_a, 0);

      // idle: strobe every DIV cycles, silent
      do_reset();
      for (int n = 1; n <= 12; n++) begin
         tick();
         chk($sformatf("idle valida n=%0d", n), val_a, (n % DIV == 0));
         chk($sformatf("idle amostra n=%0d", n), am_a, 0);
         chk($sformatf("idle vozes n=%0d", n), vz_a, 0);
      end

      // single-voice waveforms from the table
      for (int t = 0; t < 7; t++) begin
         do_reset();
         tick();
         cp_a[tab[t].voz] = tab[t].per[17:0];
         tick();
         len = (tab[t].nvoz != 0) ? 2 * tab[t].per : 8;
         for (int kk = 0; kk < len; kk++) begin
            tick();
            if (tab[t].nvoz == 0)
               x = 0;
            else
               x = ((kk % tab[t].per) < tab[t].hi) ? AMP_A : -AMP_A;
            chk($sformatf("tab%0d soma k=%0d", t, kk), int'(u_a.soma_r), x);
            if (kk == 0)
               chk($sformatf("tab%0d vozes", t), vz_a, tab[t].nvoz);
         end
         chk($sformatf("tab%0d hi+lo", t), tab[t].hi + tab[t].lo,
             (tab[t].nvoz != 0) ? tab[t].per : 0);
      end

      // period shrink below current count: wrap next edge, restart high
      do_reset();
      tick();
      cp_a[0] = 18'd100;
      tick();
      repeat (55) tick();
      chk("shrink before", int'(u_a.soma_r), -AMP_A);
      cp_a[0] = 18'd20;
      tick();
      chk("shrink edge", int'(u_a.soma_r), -AMP_A);
      for (int kk = 0; kk < 40; kk++) begin
         tick();
         chk($sformatf("shrink k=%0d", kk), int'(u_a.soma_r),
             ((kk % 20) < 10) ? AMP_A : -AMP_A);
      end

      // all voices at once on the high-amplitude instance: out-of-range sum
      do_reset();
      tick();
      tick();
      for (int i = 0; i < NV; i++) cp_b[i] = 18'd8;
      c = e;
      for (int j = 0; j < 20; j++) begin
         tick();
         if (e == c + 2) begin
            chk("full soma", int'(u_b.soma_r), NV * AMP_B);
            chk("full vozes", vz_b, NV);
         end
         chk($sformatf("full valida n=%0d", e), val_b, (e % DIV == 0));
         if (e % DIV == 0) begin
            k = e - 2 - (c + 1);
            x = (k < 0) ? 0 : red16(((k % 8) < 4) ? NV * AMP_B : -NV * AMP_B);
            chk($sformatf("full amostra n=%0d", e), am_b, x);
         end
      end
      chk("full red16 high", red16(NV * AMP_B),
`ifdef OSC_SATURA_EN
          32767
`else
          -25536
`endif
      );

      // async reset mid-note, disabled idle, re-enable timing
      do_reset();
      tick();
      cp_a[0] = 18'd8;
      repeat (9) tick();
      chk("prerst amostra nonzero", (am_a != 0), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst amostra", am_a, 0);
      chk("async rst valida", val_a, 0);
      chk("async rst vozes", vz_a, 0);
      chk("async rst soma", int'(u_a.soma_r), 0);
      tick();
      habilita = 1'b0;
      rst = 1'b0;
      for (int j = 0; j < 10; j++) begin
         tick();
         chk($sformatf("off valida j=%0d", j), val_a, 0);
         chk($sformatf("off amostra j=%0d", j), am_a, 0);
      end
      habilita = 1'b1;
      found = 0;
      found2 = 0;
      for (int j = 1; j <= 20; j++) begin
         tick();
         if (val_a && found == 0) found = j;
         else if (val_a && found2 == 0) found2 = j;
      end
      chk("reenable first strobe", found, DIV);
      chk("reenable spacing", found2 - found, DIV);
      chk("pre-disable amostra nonzero", (am_a != 0), 1);
      habilita = 1'b0;
      tick();
      chk("disable amostra", am_a, 0);
      chk("disable valida", val_a, 0);

      // randomized voice toggling against the model
      do_reset();
      for (int i = 0; i < NV; i++) begin
         on[i] = 0; ini[i] = 0; per[i] = 2;
      end
      exp_am = 0;
      for (int n = 0; n < 400; n++) begin
         if (n > 0) begin
            tick();
            chk($sformatf("rnd vozes n=%0d", n), vz_a, cnts[n-1]);
            chk($sformatf("rnd valida n=%0d", n), val_a, (n % DIV == 0));
            if (n % DIV == 0) exp_am = red16(sums[n-2]);
            chk($sformatf("rnd amostra n=%0d", n), am_a, exp_am);
         end
         if (n % 5 == 2) begin
            v = $urandom_range(0, NV - 1);
            if (on[v] != 0) begin
               cp_a[v] = ($urandom_range(0, 1) == 0) ? INAT : 18'd1;
               on[v] = 0;
            end else begin
               r = $urandom_range(0, 5);
               if (r == 0) cp_a[v] = 18'd1;
               else if (r == 1) cp_a[v] = INAT;
               else begin
                  per[v] = $urandom_range(2, 40);
                  cp_a[v] = 18'(per[v]);
                  on[v] = 1;
                  ini[v] = n + 1;
               end
            end
         end
         s = 0;
         cn = 0;
         for (int i = 0; i < NV; i++) begin
            if (on[i] != 0 && n >= ini[i]) begin
               cn++;
               s += (((n - ini[i]) % per[i]) < per[i] / 2) ? AMP_A : -AMP_A;
            end
         end
         sums[n] = s;
         cnts[n] = cn;
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/oscilador_polifonico.md
Name: oscilador_polifonico

Overview:
Polyphonic square-wave synthesis stage that sits directly downstream of the key-to-period mapper.
- Consumes one 18-bit period word per key, counted in clk cycles; all-ones means the voice is inactive.
- Runs one phase counter per voice and mixes the voice square waves into a signed PCM sum.
- Emits one sample per sample-rate tick, with a single-cycle valid strobe, to the audio output stage.

Parameters:
NR_TECLAS, 10, number of voices/keys
LARGURA_CP, 18, period word width
DIV_AMOSTRA, 1042, clk cycles per output sample (50 MHz / 48 kHz); minimum 2
AMPLITUDE, 3000, per-voice magnitude added to the mix
LARGURA_AMOSTRA, 16, signed output sample width

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
cp  in  [NR_TECLAS-1:0][LARGURA_CP-1:0]  per-voice period in clk cycles; all-ones = inactive
habilita  in  1  synthesis enable
amostra  out  LARGURA_AMOSTRA signed  mixed sample
amostra_valida  out  1  one-cycle strobe; amostra is new
vozes_ativas  out  $clog2(NR_TECLAS+1)  registered count of active voices

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all voice counters 0, soma_r 0, divider 0, amostra 0, amostra_valida 0, vozes_ativas 0.
- Voice active: cp[i] != all-ones and cp[i] >= 2. Otherwise inactive: cont[i] held at 0, contribution 0.
- Per active voice, cont[i] counts 0..cp[i]-1.
  - Wrap condition: cont[i] >= cp[i]-1, giving cont <= 0 on that edge.
  - This covers a cp decrease below the current count: the counter wraps on the next edge.
  - Period is exactly cp[i] cycles.
- Phase (combinational from registered cont): high while cont[i] < (cp[i]>>1), else low.
  - High for floor(cp/2) cycles, low for ceil(cp/2) cycles.
- Activation: the first edge sampling an active cp leaves cont=0, so every note starts in the high phase.
- Contribution: +AMPLITUDE if phase high, -AMPLITUDE if low, 0 if inactive.
- Mix: soma_r <= sum of contributions every cycle.
  - soma_r width is LARGURA_AMOSTRA+$clog2(NR_TECLAS)+1.
  - One cycle of latency from cont to soma_r.
- vozes_ativas is registered every cycle, same timing as soma_r.
- Sample tick: divider counts 0..DIV_AMOSTRA-1 and wraps. On the wrap edge:
  - amostra <= reduce(soma_r);
  - amostra_valida <= 1 for exactly one cycle.
- Valid spacing is exactly DIV_AMOSTRA cycles.
- habilita=0:
  - voice counters and divider held at 0;
  - amostra_valida 0;
  - amostra cleared to 0 on the next edge.
- Re-enable: counters restart from 0, and the first strobe comes DIV_AMOSTRA cycles later.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), regardless of phase or pending strobe.
- Simultaneous cp change and wrap: the wrap condition uses the current cp; the new cp governs from the next cycle.

Optional Feature:
OSC_SATURA_EN
- Defined: reduce() clamps soma_r to [-2^(LARGURA_AMOSTRA-1), 2^(LARGURA_AMOSTRA-1)-1].
- Undefined: reduce() truncates to the low LARGURA_AMOSTRA bits (two's-complement wrap).
- With default parameters the sum never exceeds the range, so behaviour is identical in that case.

Decomposition:
- Shared package synth_pkg holds:
  - LARGURA_CP = 18;
  - CP_INATIVO = all-ones;
  - typedef t_cp (logic [LARGURA_CP-1:0]);
  - the sample typedef t_amostra (signed [15:0]).
- The key mapper and this block both import synth_pkg.
- One sub-module, oscilador_voz: per-voice counter, active detect and phase, with signed contribution output. It is instantiated NR_TECLAS times via generate.
- Mixer, divider and output register stay in the top level.

Test Plan:
1. Reset, then release with all cp = all-ones, DIV_AMOSTRA=4 -> amostra_valida pulses every 4 cycles; amostra=0; vozes_ativas=0.
2. cp[0]=8, others inactive -> soma_r runs +3000 for 4 cycles then -3000 for 4 cycles, repeating; first +3000 appears one cycle after activation; vozes_ativas=1.
3. cp[3]=7 -> +3000 for 3 cycles, -3000 for 4 cycles; cp[5]=1 -> treated inactive, vozes_ativas unchanged.
4. cp[0]=100, then after 50 cycles changed to 20 -> counter wraps on the next edge; phase restarts high; subsequent period 20.
5. AMPLITUDE=4000, all 10 voices activated on the same edge with cp=8 -> soma_r=40000 in the high phase; amostra=32767 with OSC_SATURA_EN; amostra=-25536 without.
6. rst asserted mid-note between edges -> outputs 0 immediately; habilita=0 for 10 cycles -> no strobes, amostra=0; re-enable -> first strobe exactly DIV_AMOSTRA cycles later.
